// File: rtl/uart_cmd_parser.sv
// ASCII command parser: "W aa dd CR" writes and "R aa CR" reads, issued as one-cycle strobes.
// Define UART_CMD_TIMEOUT_EN to discard partial commands after TIMEOUT_CYCLES idle cycles.
module uart_cmd_parser #(
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter int unsigned TO_W           = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       we,
    output logic       re,
    output logic [7:0] w_addr,
    output logic [7:0] w_data,
    output logic [7:0] r_addr,
    output logic       cmd_err,
    output logic       busy
);

    typedef enum logic [3:0] {
        StIdle,
        StWAh,
        StWAl,
        StWDh,
        StWDl,
        StRAh,
        StRAl,
        StWaitCr,
        StError
    } state_e;

    localparam logic [7:0] ChCr    = 8'h0D;
    localparam logic [7:0] ChLf    = 8'h0A;
    localparam logic [7:0] ChSpace = 8'h20;

    state_e     state_q, state_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] data_q, data_d;
    logic       is_wr_q, is_wr_d;
    logic       err_d;
    logic       commit_w, commit_r;
    logic       timeout;
    logic       hex_ok;
    logic [3:0] hex_nib;

    // Returns {valid, nibble} for an ASCII hex digit.
    function automatic logic [4:0] hex_decode(input logic [7:0] b);
        logic [7:0] t;
        t = 8'h00;
        if (b >= 8'h30 && b <= 8'h39) begin
            t = b - 8'h30;
            return {1'b1, t[3:0]};
        end else if (b >= 8'h41 && b <= 8'h46) begin
            t = b - 8'h37;
            return {1'b1, t[3:0]};
        end else if (b >= 8'h61 && b <= 8'h66) begin
            t = b - 8'h57;
            return {1'b1, t[3:0]};
        end
        return 5'b0_0000;
    endfunction

    assign {hex_ok, hex_nib} = hex_decode(rx_data);

`ifdef UART_CMD_TIMEOUT_EN
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;

    assign timeout = (state_q != StIdle) && (to_cnt_q == TO_W'(TIMEOUT_CYCLES));

    always_comb begin
        to_cnt_d = to_cnt_q + 1'b1;
        if (state_q == StIdle || timeout || rx_valid) begin
            to_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        data_d   = data_q;
        is_wr_d  = is_wr_q;
        err_d    = 1'b0;
        commit_w = 1'b0;
        commit_r = 1'b0;
        if (timeout) begin
            // A byte arriving in the timeout cycle is dropped.
            state_d = StIdle;
            err_d   = 1'b1;
        end else if (rx_valid) begin
            case (state_q)
                StIdle: begin
                    if (rx_data == 8'h57 || rx_data == 8'h77) begin
                        state_d = StWAh;
                        is_wr_d = 1'b1;
                    end else if (rx_data == 8'h52 || rx_data == 8'h72) begin
                        state_d = StRAh;
                        is_wr_d = 1'b0;
                    end else if (rx_data != ChCr && rx_data != ChLf) begin
                        state_d = StError;
                        err_d   = 1'b1;
                    end
                end
                StWAh, StWAl, StWDh, StWDl, StRAh, StRAl: begin
                    if (rx_data == ChSpace) begin
                        state_d = state_q;
                    end else if (!hex_ok) begin
                        state_d = StError;
                        err_d   = 1'b1;
                    end else begin
                        if (state_q == StWDh || state_q == StWDl) begin
                            data_d = {data_q[3:0], hex_nib};
                        end else begin
                            addr_d = {addr_q[3:0], hex_nib};
                        end
                        case (state_q)
                            StWAh:   state_d = StWAl;
                            StWAl:   state_d = StWDh;
                            StWDh:   state_d = StWDl;
                            StRAh:   state_d = StRAl;
                            default: state_d = StWaitCr;
                        endcase
                    end
                end
                StWaitCr: begin
                    if (rx_data == ChCr) begin
                        state_d  = StIdle;
                        commit_w = is_wr_q;
                        commit_r = !is_wr_q;
                    end else if (rx_data != ChSpace) begin
                        state_d = StError;
                        err_d   = 1'b1;
                    end
                end
                StError: begin
                    if (rx_data == ChCr) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            addr_q  <= 8'h00;
            data_q  <= 8'h00;
            is_wr_q <= 1'b0;
            we      <= 1'b0;
            re      <= 1'b0;
            w_addr  <= 8'h00;
            w_data  <= 8'h00;
            r_addr  <= 8'h00;
            cmd_err <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            is_wr_q <= is_wr_d;
            we      <= commit_w;
            re      <= commit_r;
            cmd_err <= err_d;
            if (commit_w) begin
                w_addr <= addr_q;
                w_data <= data_q;
            end
            if (commit_r) begin
                r_addr <= addr_q;
            end
        end
    end

    assign busy = (state_q != StIdle);

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed bench for uart_cmd_parser; bytes are driven back to back on falling edges.
// With UART_CMD_TIMEOUT_EN defined the idle-timeout step expects an abort after 100 cycles.
module tb_uart_cmd_parser;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       we, re, cmd_err, busy;
    logic [7:0] w_addr, w_data, r_addr;

    int n_pass  = 0;
    int n_total = 0;

    uart_cmd_parser #(
        .TIMEOUT_CYCLES(100),
        .TO_W          (20)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .rx_data (rx_data),
        .rx_valid(rx_valid),
        .we      (we),
        .re      (re),
        .w_addr  (w_addr),
        .w_data  (w_data),
        .r_addr  (r_addr),
        .cmd_err (cmd_err),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%02h expected 0x%02h", tag, obs, exp);
    endtask

    // Present one byte for one cycle; returns at the next falling edge.
    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        logic seen_err;
        reset    = 1'b1;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        idle(3);
        check("rst_we", we, 0);
        check("rst_re", re, 0);
        check("rst_err", cmd_err, 0);
        check("rst_busy", busy, 0);
        check("rst_waddr", w_addr, 0);
        check("rst_wdata", w_data, 0);
        check("rst_raddr", r_addr, 0);
        reset = 1'b0;
        idle(1);

        // "W3A5C\r"
        send(8'h57); send(8'h33); send(8'h41); send(8'h35); send(8'h43);
        check("wr_busy_before_cr", busy, 1);
        check("wr_we_before_cr", we, 0);
        send(8'h0D);
        check("wr_we", we, 1);
        check("wr_waddr", w_addr, 8'h3A);
        check("wr_wdata", w_data, 8'h5C);
        check("wr_re", re, 0);
        check("wr_err", cmd_err, 0);
        check("wr_busy_after", busy, 0);
        idle(1);
        check("wr_we_one_cycle", we, 0);

        // "r 3a\r"
        send(8'h72); send(8'h20); send(8'h33); send(8'h61); send(8'h0D);
        check("rd_re", re, 1);
        check("rd_raddr", r_addr, 8'h3A);
        check("rd_we", we, 0);
        check("rd_waddr_hold", w_addr, 8'h3A);
        idle(1);
        check("rd_re_one_cycle", re, 0);

        // "W1G..\r" then "R05\r"
        send(8'h57); send(8'h31); send(8'h47);
        check("bad_err_pulse", cmd_err, 1);
        check("bad_busy", busy, 1);
        send(8'h2E);
        check("bad_err_once", cmd_err, 0);
        check("bad_busy_hold", busy, 1);
        send(8'h2E); send(8'h0D);
        check("bad_busy_after_cr", busy, 0);
        check("bad_no_we", we, 0);
        check("bad_no_err_cr", cmd_err, 0);
        send(8'h52); send(8'h30); send(8'h35); send(8'h0D);
        check("bad_then_re", re, 1);
        check("bad_then_raddr", r_addr, 8'h05);

        // "R01\r" with 'W' arriving in the re strobe cycle, then "FF01\r"
        idle(1);
        send(8'h52); send(8'h30); send(8'h31); send(8'h0D);
        check("b2b_re", re, 1);
        check("b2b_raddr", r_addr, 8'h01);
        send(8'h57);
        check("b2b_busy", busy, 1);
        check("b2b_re_low", re, 0);
        send(8'h46); send(8'h66); send(8'h30); send(8'h31); send(8'h0D);
        check("b2b_we", we, 1);
        check("b2b_waddr", w_addr, 8'hFF);
        check("b2b_wdata", w_data, 8'h01);
        check("b2b_re_still_low", re, 0);

        // Reset after "W12", then "4\r"
        idle(1);
        send(8'h57); send(8'h31); send(8'h32);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_we", we, 0);
        check("mid_rst_err", cmd_err, 0);
        check("mid_rst_waddr", w_addr, 0);
        check("mid_rst_wdata", w_data, 0);
        check("mid_rst_raddr", r_addr, 0);
        send(8'h34);
        check("idle_digit_err", cmd_err, 1);
        check("idle_digit_busy", busy, 1);
        send(8'h0D);
        check("idle_digit_cr_busy", busy, 0);
        check("idle_digit_cr_we", we, 0);

        // LF ignored in IDLE, space is an error in IDLE
        send(8'h0A);
        check("lf_idle_busy", busy, 0);
        check("lf_idle_err", cmd_err, 0);
        send(8'h20);
        check("sp_idle_err", cmd_err, 1);
        send(8'h0D);
        check("sp_idle_cr_busy", busy, 0);

        // "W1" then a long idle gap
        send(8'h57); send(8'h31);
        seen_err = 1'b0;
        for (int i = 0; i < 110; i++) begin
            @(negedge clk);
            if (cmd_err) seen_err = 1'b1;
        end
`ifdef UART_CMD_TIMEOUT_EN
        check("to_err_seen", seen_err, 1);
        check("to_busy", busy, 0);
`else
        check("to_no_err", seen_err, 0);
        check("to_busy_hold", busy, 1);
`endif
        check("to_no_we", we, 0);
        send(8'h0D); send(8'h0D);
        check("to_cleanup_busy", busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
